// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator ALU sequencer.
// Command op codes, one-hot ALU op pins, sequencer states, error result codes.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } cmd_op_e;

    localparam logic [3:0] ALU_ADD  = 4'b1000;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0001;
    localparam logic [3:0] ALU_IDLE = 4'b0000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        CAPTURE   = 3'd4,
        HOLD      = 3'd5
    } seq_state_e;

    localparam logic [7:0] ERR_DIV0    = 8'h00;
    localparam logic [7:0] ERR_TIMEOUT = 8'hFF;

    function automatic logic [3:0] alu_onehot(input cmd_op_e op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_MUL:  return ALU_MUL;
            default: return ALU_DIV;
        endcase
    endfunction

    function automatic logic is_multicycle(input cmd_op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/calc_seq_watchdog.sv
// Wait-state watchdog: down-counter reloaded on clear, expires at terminal count
// after TIMEOUT enabled cycles. Only instantiated with CALC_SEQ_WATCHDOG_EN.
module calc_seq_watchdog #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= LOAD;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = enable && (cnt == '0);

endmodule

// File: rtl/calc_alu_sequencer.sv
// Initiator side of the calculator ALU interface: command in, ALU handshake, result out.
// Optional wait-state watchdog enabled by defining CALC_SEQ_WATCHDOG_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | cmd_ready high, ALU op idle, waiting for a command
// ISSUE     | one-hot op on the ALU pins for one cycle
// WAIT_BUSY | mul/div: op held, waiting for the ALU to raise busy
// WAIT_DONE | mul/div: op held, waiting for the ALU to drop busy
// CAPTURE   | op released, ALU result sampled
// HOLD      | result presented until res_ready
module calc_alu_sequencer
    import calc_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic       cmd_sign,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_err,
    output logic [3:0] alu_op,
    output logic       alu_sign,
    output logic [3:0] alu_data1,
    output logic [3:0] alu_data2,
    input  logic [7:0] alu_o,
    input  logic       alu_busy,
    output logic       seq_busy
);
    seq_state_e state;
    cmd_op_e    op_q;
    cmd_op_e    cmd_op_e_w;
    logic       wd_expired;

    assign cmd_op_e_w = cmd_op_e'(cmd_op);
    assign seq_busy   = (state != IDLE);

`ifdef CALC_SEQ_WATCHDOG_EN
    logic wd_clear;
    logic wd_enable;

    // Reload on every entry into a wait state, including WAIT_BUSY -> WAIT_DONE.
    assign wd_clear  = ((state == ISSUE) && is_multicycle(op_q)) ||
                       ((state == WAIT_BUSY) && alu_busy && !wd_expired);
    assign wd_enable = (state == WAIT_BUSY) || (state == WAIT_DONE);

    calc_seq_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_ADD;
            cmd_ready <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= 8'h00;
            res_err   <= 1'b0;
            alu_op    <= ALU_IDLE;
            alu_sign  <= 1'b0;
            alu_data1 <= 4'h0;
            alu_data2 <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op_e_w;
                        if ((cmd_op_e_w == OP_DIV) && (cmd_b == 4'h0)) begin
                            // Divide by zero never reaches the ALU pins.
                            res_data  <= ERR_DIV0;
                            res_err   <= 1'b1;
                            res_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            alu_op    <= alu_onehot(cmd_op_e_w);
                            alu_sign  <= cmd_sign;
                            alu_data1 <= cmd_a;
                            alu_data2 <= cmd_b;
                            state     <= ISSUE;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (is_multicycle(op_q)) begin
                        state <= WAIT_BUSY;
                    end else begin
                        alu_op <= ALU_IDLE;
                        state  <= CAPTURE;
                    end
                end
                WAIT_BUSY, WAIT_DONE: begin
                    if (wd_expired) begin
                        alu_op    <= ALU_IDLE;
                        res_data  <= ERR_TIMEOUT;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else if ((state == WAIT_BUSY) && alu_busy) begin
                        state <= WAIT_DONE;
                    end else if ((state == WAIT_DONE) && !alu_busy) begin
                        // Releasing the op here keeps the ALU from restarting.
                        alu_op <= ALU_IDLE;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    res_data  <= is_multicycle(op_q) ? alu_o : {3'b000, alu_o[4:0]};
                    res_err   <= 1'b0;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    alu_op    <= ALU_IDLE;
                    res_valid <= 1'b0;
                    cmd_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Self-checking bench for calc_alu_sequencer with a behavioural ALU and a result scoreboard.
// Watchdog scenario runs only when CALC_SEQ_WATCHDOG_EN is defined.
module tb_calc_alu_sequencer;

`ifdef CALC_SEQ_WATCHDOG_EN
    localparam int TB_TO = 8;
`else
    localparam int TB_TO = 32;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_sign;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a, cmd_b;
    logic       res_valid, res_ready, res_err;
    logic [7:0] res_data;
    logic [3:0] alu_op, alu_data1, alu_data2;
    logic       alu_sign, alu_busy, seq_busy;
    logic [7:0] alu_o;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb_q[$];

    int         busy_len = 1;
    logic       alu_stuck = 1'b0;
    logic       m_started;
    int         m_left;

    always #5 clk = ~clk;

    calc_alu_sequencer #(.TIMEOUT(TB_TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sign(cmd_sign), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .alu_op(alu_op), .alu_sign(alu_sign), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_o(alu_o), .alu_busy(alu_busy), .seq_busy(seq_busy)
    );

    // Behavioural ALU: add/sub registered in one cycle, mul/div raise busy for busy_len cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_busy <= 1'b0; alu_o <= 8'h00; m_started <= 1'b0; m_left <= 0;
        end else if (alu_op == 4'b0000) begin
            m_started <= 1'b0;
            if (!alu_stuck) alu_busy <= 1'b0;
        end else if (alu_op == 4'b1000) begin
            alu_o <= {4'h0, alu_data1} + {4'h0, alu_data2};
        end else if (alu_op == 4'b0100) begin
            alu_o <= {4'h0, alu_data1} - {4'h0, alu_data2};
        end else if (!m_started) begin
            m_started <= 1'b1; alu_busy <= 1'b1; m_left <= busy_len;
        end else if (alu_busy && !alu_stuck) begin
            if (m_left <= 1) begin
                alu_busy <= 1'b0;
                alu_o <= (alu_op == 4'b0010) ? ({4'h0, alu_data1} * {4'h0, alu_data2})
                                             : ({4'h0, alu_data1} / {4'h0, alu_data2});
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    function automatic logic [8:0] exp_of(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] s;
        case (op)
            2'd0: begin s = {4'h0, a} + {4'h0, b}; return {1'b0, 3'b000, s[4:0]}; end
            2'd1: begin s = {4'h0, a} - {4'h0, b}; return {1'b0, 3'b000, s[4:0]}; end
            2'd2: begin s = {4'h0, a} * {4'h0, b}; return {1'b0, s}; end
            default: begin
                if (b == 4'h0) return {1'b1, 8'h00};
                s = {4'h0, a} / {4'h0, b}; return {1'b0, s};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [3:0] b, input int len);
        if (op < 2'd2) return 3;
        if (op == 2'd3 && b == 4'h0) return 1;
        return 4 + len;
    endfunction

    function automatic logic [3:0] exp_onehot(input logic [1:0] op);
        logic [3:0] v;
        v = 4'b1000 >> op;
        return v;
    endfunction

    // Drives one command, pushes its expectation, and measures the DUT up to res_valid.
    task automatic do_op(input logic [1:0] op, input logic sign, input logic [3:0] a,
                         input logic [3:0] b, input logic [8:0] expv,
                         output int lat, output int op_cycles, output logic op_ok,
                         output logic [8:0] issue_vals, output logic timed_out);
        int n;
        logic seen;
        lat = 0; op_cycles = 0; op_ok = 1'b1; issue_vals = '0; timed_out = 1'b0; seen = 1'b0;
        @(negedge clk);
        cmd_op = op; cmd_sign = sign; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin timed_out = 1'b1; cmd_valid = 1'b0; return; end
        sb_q.push_back(expv);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a = ~a; cmd_b = ~b;
        lat = 1;
        while (!res_valid && lat < 200) begin
            if (alu_op != 4'b0000) begin
                op_cycles++;
                if (alu_op != exp_onehot(op)) op_ok = 1'b0;
                if (!seen) begin issue_vals = {alu_sign, alu_data1, alu_data2}; seen = 1'b1; end
            end
            @(negedge clk);
            lat++;
        end
        if (!res_valid) timed_out = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_sign = 1'b0;
        cmd_a = 4'h0; cmd_b = 4'h0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({cmd_ready, res_valid, res_err, seq_busy} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags got=%b exp=0000", {cmd_ready, res_valid, res_err, seq_busy}); end
        checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_res_data got=%h exp=00", res_data); end
        checks++; if ({alu_op, alu_sign, alu_data1, alu_data2} !== 13'h0) begin errors++;
            $display("FAIL reset_alu_pins got=%h exp=0", {alu_op, alu_sign, alu_data1, alu_data2}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_add;
        int lat, opc; logic ok, to; logic [8:0] iv, e;
        do_op(2'd0, 1'b0, 4'd7, 4'd5, exp_of(2'd0, 4'd7, 4'd5), lat, opc, ok, iv, to);
        checks++; if (to || lat != 3) begin errors++; $display("FAIL add_latency got=%0d exp=3", lat); end
        checks++; if (opc != 1 || !ok) begin errors++; $display("FAIL add_op_cycles got=%0d exp=1", opc); end
        checks++; if (iv !== {1'b0, 4'd7, 4'd5}) begin errors++; $display("FAIL add_operands got=%h exp=%h", iv, {1'b0, 4'd7, 4'd5}); end
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
        checks++; if ({res_err, res_data} !== e || e !== 9'h00C) begin errors++;
            $display("FAIL add_result got=%h exp=00C", {res_err, res_data}); end
        @(negedge clk);
    endtask

    task automatic test_mul;
        int lat, opc; logic ok, to; logic [8:0] e;
        logic [8:0] iv;
        busy_len = 3;
        do_op(2'd2, 1'b0, 4'd3, 4'd5, exp_of(2'd2, 4'd3, 4'd5), lat, opc, ok, iv, to);
        checks++; if (to || lat != 7) begin errors++; $display("FAIL mul_latency got=%0d exp=7", lat); end
        checks++; if (opc != 5 || !ok) begin errors++; $display("FAIL mul_op_held got=%0d exp=5", opc); end
        checks++; if (alu_op !== 4'b0000) begin errors++; $display("FAIL mul_op_released got=%b exp=0000", alu_op); end
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
        checks++; if ({res_err, res_data} !== e || e !== 9'h00F) begin errors++;
            $display("FAIL mul_result got=%h exp=00F", {res_err, res_data}); end
        @(negedge clk);
    endtask

    task automatic test_div_zero;
        int lat, opc; logic ok, to; logic [8:0] iv, e;
        do_op(2'd3, 1'b0, 4'd9, 4'd0, exp_of(2'd3, 4'd9, 4'd0), lat, opc, ok, iv, to);
        checks++; if (to || lat != 1) begin errors++; $display("FAIL div0_latency got=%0d exp=1", lat); end
        checks++; if (opc != 0 || alu_op !== 4'b0000) begin errors++; $display("FAIL div0_alu_driven got=%0d exp=0", opc); end
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h0FF;
        checks++; if ({res_err, res_data} !== e || e !== 9'h100) begin errors++;
            $display("FAIL div0_result got=%h exp=100", {res_err, res_data}); end
        @(negedge clk);
    endtask

    task automatic test_hold_backpressure;
        int lat, opc, n; logic ok, to; logic [8:0] iv, e; logic [7:0] d0;
        busy_len = 2;
        res_ready = 1'b0;
        do_op(2'd2, 1'b0, 4'd6, 4'd7, exp_of(2'd2, 4'd6, 4'd7), lat, opc, ok, iv, to);
        d0 = res_data;
        cmd_op = 2'd0; cmd_a = 4'd1; cmd_b = 4'd1; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (res_valid !== 1'b1 || res_data !== d0 || cmd_ready !== 1'b0) begin errors++;
                $display("FAIL hold_stable cyc=%0d got=%b%h%b exp=1%h0", i, res_valid, res_data, cmd_ready, d0); end
            @(negedge clk);
        end
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
        checks++; if ({res_err, res_data} !== e || e !== 9'h02A) begin errors++;
            $display("FAIL hold_result got=%h exp=02A", {res_err, res_data}); end
        res_ready = 1'b1;
        @(negedge clk);
        checks++; if (res_valid !== 1'b0 || seq_busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++;
            $display("FAIL hold_release got=%b%b%b exp=001", res_valid, seq_busy, cmd_ready); end
        sb_q.push_back(exp_of(2'd0, 4'd1, 4'd1));
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (seq_busy !== 1'b1) begin errors++; $display("FAIL hold_pending_accept got=%b exp=1", seq_busy); end
        n = 0;
        while (!res_valid && n < 20) begin @(negedge clk); n++; end
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
        checks++; if (!res_valid || {res_err, res_data} !== e) begin errors++;
            $display("FAIL hold_pending_result got=%h exp=%h", {res_err, res_data}, e); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [1:0] ops[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
        logic [3:0] as[5]  = '{4'd3, 4'd15, 4'd14, 4'd15, 4'd7};
        logic [3:0] bs[5]  = '{4'd9, 4'd15, 4'd3, 4'd15, 4'd0};
        int lat, opc, len; logic ok, to; logic [8:0] iv, e, x;
        logic [1:0] op; logic [3:0] a, b; logic sg;
        for (int i = 0; i < 11; i++) begin
            if (i < 5) begin op = ops[i]; a = as[i]; b = bs[i]; end
            else begin op = 2'($urandom_range(3)); a = 4'($urandom); b = 4'($urandom); end
            sg = 1'($urandom);
            len = $urandom_range(1, 4);
            busy_len = len;
            x = exp_of(op, a, b);
            do_op(op, sg, a, b, x, lat, opc, ok, iv, to);
            checks++; if (to || lat != exp_lat(op, b, len) || !ok) begin errors++;
                $display("FAIL b2b_latency i=%0d op=%0d got=%0d exp=%0d", i, op, lat, exp_lat(op, b, len)); end
            if (exp_lat(op, b, len) != 1) begin
                checks++; if (iv !== {sg, a, b}) begin errors++;
                    $display("FAIL b2b_operands i=%0d got=%h exp=%h", i, iv, {sg, a, b}); end
            end
            e = (sb_q.size() > 0) ? sb_q.pop_front() : ~x;
            checks++; if ({res_err, res_data} !== e) begin errors++;
                $display("FAIL b2b_result i=%0d got=%h exp=%h", i, {res_err, res_data}, e); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n, lat, opc; logic ok, to; logic [8:0] iv, e;
        busy_len = 30;
        @(negedge clk);
        cmd_op = 2'd2; cmd_a = 4'd4; cmd_b = 4'd4; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(alu_busy && seq_busy) && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        checks++; if (alu_op !== 4'b0010) begin errors++; $display("FAIL rstmid_in_wait got=%b exp=0010", alu_op); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (alu_op !== 4'b0000 || res_valid !== 1'b0 || seq_busy !== 1'b0) begin errors++;
            $display("FAIL rstmid_idle got=%b%b%b exp=000000", alu_op, res_valid, seq_busy); end
        busy_len = 1;
        do_op(2'd0, 1'b0, 4'd2, 4'd2, exp_of(2'd0, 4'd2, 4'd2), lat, opc, ok, iv, to);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
        checks++; if (to || lat != 3 || {res_err, res_data} !== e || e !== 9'h004) begin errors++;
            $display("FAIL rstmid_add got=%h lat=%0d exp=004 lat=3", {res_err, res_data}, lat); end
        @(negedge clk);
    endtask

`ifdef CALC_SEQ_WATCHDOG_EN
    task automatic test_timeout;
        int lat, opc; logic ok, to; logic [8:0] iv, e;
        alu_stuck = 1'b1;
        busy_len = 1;
        do_op(2'd2, 1'b0, 4'd3, 4'd5, {1'b1, 8'hFF}, lat, opc, ok, iv, to);
        checks++; if (to || lat != 3 + TB_TO) begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, 3 + TB_TO); end
        checks++; if (alu_op !== 4'b0000) begin errors++; $display("FAIL timeout_op got=%b exp=0000", alu_op); end
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h000;
        checks++; if ({res_err, res_data} !== e) begin errors++;
            $display("FAIL timeout_result got=%h exp=%h", {res_err, res_data}, e); end
        alu_stuck = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div_zero();
        test_hold_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef CALC_SEQ_WATCHDOG_EN
        test_timeout();
`endif
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
